// File: rtl/tlul_arbiter_2to1_if.sv
// rtl/tlul_arbiter_2to1_if.sv - TL-UL A/D channel bundle shared by the 2:1 arbiter ports
interface tlul_arbiter_2to1_if #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MASK_WIDTH   = DATA_WIDTH / 8,
    parameter int SIZE_WIDTH   = 3,
    parameter int OPCODE_WIDTH = 3
) ();
    logic                    a_valid;
    logic                    a_ready;
    logic [OPCODE_WIDTH-1:0] a_opcode;
    logic [SIZE_WIDTH-1:0]   a_size;
    logic [ADDR_WIDTH-1:0]   a_address;
    logic [MASK_WIDTH-1:0]   a_mask;
    logic [DATA_WIDTH-1:0]   a_data;
    logic                    d_valid;
    logic                    d_ready;
    logic [OPCODE_WIDTH-1:0] d_opcode;
    logic [DATA_WIDTH-1:0]   d_data;
    logic                    d_denied;

    modport master (
        output a_valid, a_opcode, a_size, a_address, a_mask, a_data, d_ready,
        input  a_ready, d_valid, d_opcode, d_data, d_denied
    );

    modport slave (
        input  a_valid, a_opcode, a_size, a_address, a_mask, a_data, d_ready,
        output a_ready, d_valid, d_opcode, d_data, d_denied
    );
endinterface

// File: rtl/tlul_arbiter_2to1.sv
// rtl/tlul_arbiter_2to1.sv - round-robin 2:1 TL-UL arbiter, one outstanding transaction
// Optional D-wait timeout with synthesized denied response: TLUL_ARB_TIMEOUT_EN
module tlul_arbiter_2to1 #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MASK_WIDTH   = DATA_WIDTH / 8,
    parameter int SIZE_WIDTH   = 3,
    parameter int OPCODE_WIDTH = 3
`ifdef TLUL_ARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                 clk_24,
    input  logic                 rst,
    tlul_arbiter_2to1_if.slave   m0,
    tlul_arbiter_2to1_if.slave   m1,
    tlul_arbiter_2to1_if.master  s,
    output logic                 grant,
    output logic                 busy
);

`ifdef TLUL_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, A_SEND, D_WAIT, D_ERR} state_t;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]        d_cnt;
    logic [OPCODE_WIDTH-1:0] a_op_q;
`else
    typedef enum logic [1:0] {IDLE, A_SEND, D_WAIT} state_t;
`endif

    state_t state;
    logic   last_grant;

    logic                    g_a_valid;
    logic [OPCODE_WIDTH-1:0] g_a_opcode;
    logic [SIZE_WIDTH-1:0]   g_a_size;
    logic [ADDR_WIDTH-1:0]   g_a_address;
    logic [MASK_WIDTH-1:0]   g_a_mask;
    logic [DATA_WIDTH-1:0]   g_a_data;
    logic                    g_d_ready;

    logic                    d_fwd;
    logic [OPCODE_WIDTH-1:0] d_op;
    logic [DATA_WIDTH-1:0]   d_dat;
    logic                    d_den;
    logic                    s_d_rdy;

    assign g_a_valid   = grant ? m1.a_valid   : m0.a_valid;
    assign g_a_opcode  = grant ? m1.a_opcode  : m0.a_opcode;
    assign g_a_size    = grant ? m1.a_size    : m0.a_size;
    assign g_a_address = grant ? m1.a_address : m0.a_address;
    assign g_a_mask    = grant ? m1.a_mask    : m0.a_mask;
    assign g_a_data    = grant ? m1.a_data    : m0.a_data;
    assign g_d_ready   = grant ? m1.d_ready   : m0.d_ready;

    always_ff @(posedge clk_24) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
`ifdef TLUL_ARB_TIMEOUT_EN
            d_cnt      <= '0;
            a_op_q     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (m0.a_valid && m1.a_valid) begin
                        grant <= ~last_grant;
                        state <= A_SEND;
                    end else if (m0.a_valid) begin
                        grant <= 1'b0;
                        state <= A_SEND;
                    end else if (m1.a_valid) begin
                        grant <= 1'b1;
                        state <= A_SEND;
                    end
                end
                A_SEND: begin
                    // A request withdrawn before acceptance: abandon without moving the pointer
                    if (!g_a_valid) begin
                        state <= IDLE;
                    end else if (s.a_ready) begin
                        state <= D_WAIT;
`ifdef TLUL_ARB_TIMEOUT_EN
                        d_cnt  <= '0;
                        a_op_q <= g_a_opcode;
`endif
                    end
                end
                D_WAIT: begin
                    if (s.d_valid && g_d_ready) begin
                        state      <= IDLE;
                        last_grant <= grant;
                    end
`ifdef TLUL_ARB_TIMEOUT_EN
                    else if (d_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state <= D_ERR;
                        d_cnt <= d_cnt + CNT_W'(1);
                    end else begin
                        d_cnt <= d_cnt + CNT_W'(1);
                    end
`endif
                end
`ifdef TLUL_ARB_TIMEOUT_EN
                D_ERR: begin
                    if (g_d_ready) begin
                        state      <= IDLE;
                        last_grant <= grant;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

    assign s.a_valid   = (state == A_SEND) ? g_a_valid   : 1'b0;
    assign s.a_opcode  = (state == A_SEND) ? g_a_opcode  : '0;
    assign s.a_size    = (state == A_SEND) ? g_a_size    : '0;
    assign s.a_address = (state == A_SEND) ? g_a_address : '0;
    assign s.a_mask    = (state == A_SEND) ? g_a_mask    : '0;
    assign s.a_data    = (state == A_SEND) ? g_a_data    : '0;

    assign m0.a_ready = (state == A_SEND) && !grant && s.a_ready;
    assign m1.a_ready = (state == A_SEND) &&  grant && s.a_ready;

    always_comb begin
        d_fwd   = 1'b0;
        d_op    = '0;
        d_dat   = '0;
        d_den   = 1'b0;
        s_d_rdy = 1'b0;
        if (state == D_WAIT) begin
            d_fwd   = s.d_valid;
            d_op    = s.d_opcode;
            d_dat   = s.d_data;
            d_den   = s.d_denied;
            s_d_rdy = g_d_ready;
        end
`ifdef TLUL_ARB_TIMEOUT_EN
        // Synthesized error response; late slave beats are sunk meanwhile
        if (state == D_ERR) begin
            d_fwd   = 1'b1;
            d_op    = (a_op_q == OPCODE_WIDTH'(4)) ? OPCODE_WIDTH'(1) : '0;
            d_den   = 1'b1;
            s_d_rdy = 1'b1;
        end
`endif
    end

    assign s.d_ready = s_d_rdy;

    assign m0.d_valid  = d_fwd && !grant;
    assign m0.d_opcode = m0.d_valid ? d_op  : '0;
    assign m0.d_data   = m0.d_valid ? d_dat : '0;
    assign m0.d_denied = m0.d_valid ? d_den : 1'b0;

    assign m1.d_valid  = d_fwd && grant;
    assign m1.d_opcode = m1.d_valid ? d_op  : '0;
    assign m1.d_data   = m1.d_valid ? d_dat : '0;
    assign m1.d_denied = m1.d_valid ? d_den : 1'b0;

endmodule

// File: tb/tb_tlul_arbiter_2to1.sv
// tb/tb_tlul_arbiter_2to1.sv - directed self-checking bench for tlul_arbiter_2to1
module tb_tlul_arbiter_2to1;

    logic clk_24 = 1'b0;
    logic rst;
    logic grant;
    logic busy;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] mem [logic [31:0]];

    always #5 clk_24 = ~clk_24;

    tlul_arbiter_2to1_if m0_bus ();
    tlul_arbiter_2to1_if m1_bus ();
    tlul_arbiter_2to1_if s_bus ();

`ifdef TLUL_ARB_TIMEOUT_EN
    tlul_arbiter_2to1 #(.TIMEOUT_CYCLES(8)) dut (
`else
    tlul_arbiter_2to1 dut (
`endif
        .clk_24 (clk_24),
        .rst    (rst),
        .m0     (m0_bus),
        .m1     (m1_bus),
        .s      (s_bus),
        .grant  (grant),
        .busy   (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_m(input int idx, input logic v, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] data);
        if (idx == 0) begin
            m0_bus.a_valid = v; m0_bus.a_opcode = op; m0_bus.a_address = addr;
            m0_bus.a_data = data; m0_bus.a_size = 3'd2; m0_bus.a_mask = 4'hF;
        end else begin
            m1_bus.a_valid = v; m1_bus.a_opcode = op; m1_bus.a_address = addr;
            m1_bus.a_data = data; m1_bus.a_size = 3'd2; m1_bus.a_mask = 4'hF;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk_24);
        #1;
        check("rst_busy", busy, 0);
        check("rst_m0_a_ready", m0_bus.a_ready, 0);
        check("rst_m1_a_ready", m1_bus.a_ready, 0);
        check("rst_m0_d_valid", m0_bus.d_valid, 0);
        check("rst_m1_d_valid", m1_bus.d_valid, 0);
        check("rst_s_a_valid", s_bus.a_valid, 0);
        rst = 1'b0;
    endtask

    // Entered at a negedge in IDLE with requests presented; returns at the negedge back in IDLE
    task automatic serve(input string tag, input logic exp_g, input logic [31:0] exp_addr,
                         input logic [2:0] exp_rop, input logic [31:0] exp_rdata);
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wd;
        #1;
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_s_a_valid"}, s_bus.a_valid, 0);
        @(negedge clk_24); #1;
        check({tag, "_busy"}, busy, 1);
        check({tag, "_grant"}, grant, exp_g);
        check({tag, "_s_a_valid"}, s_bus.a_valid, 1);
        check({tag, "_s_a_address"}, s_bus.a_address, exp_addr);
        check({tag, "_g_a_ready"}, exp_g ? m1_bus.a_ready : m0_bus.a_ready, 1);
        check({tag, "_o_a_ready"}, exp_g ? m0_bus.a_ready : m1_bus.a_ready, 0);
        op   = s_bus.a_opcode;
        addr = s_bus.a_address;
        wd   = s_bus.a_data;
        @(negedge clk_24);
        s_bus.d_valid  = 1'b1;
        s_bus.d_denied = 1'b0;
        if (op == 3'd4) begin
            s_bus.d_opcode = 3'd1;
            s_bus.d_data   = mem.exists(addr) ? mem[addr] : 32'h0;
        end else begin
            s_bus.d_opcode = 3'd0;
            s_bus.d_data   = 32'h0;
            mem[addr]      = wd;
        end
        #1;
        check({tag, "_d_valid"}, exp_g ? m1_bus.d_valid : m0_bus.d_valid, 1);
        check({tag, "_d_opcode"}, exp_g ? m1_bus.d_opcode : m0_bus.d_opcode, exp_rop);
        check({tag, "_d_data"}, exp_g ? m1_bus.d_data : m0_bus.d_data, exp_rdata);
        check({tag, "_d_denied"}, exp_g ? m1_bus.d_denied : m0_bus.d_denied, 0);
        check({tag, "_o_d_valid"}, exp_g ? m0_bus.d_valid : m1_bus.d_valid, 0);
        check({tag, "_s_d_ready"}, s_bus.d_ready, 1);
        check({tag, "_dw_s_a_valid"}, s_bus.a_valid, 0);
        @(negedge clk_24);
        s_bus.d_valid  = 1'b0;
        s_bus.d_opcode = 3'd0;
        s_bus.d_data   = 32'h0;
    endtask

    initial begin
        rst = 1'b1;
        set_m(0, 1'b0, 3'd0, 32'h0, 32'h0);
        set_m(1, 1'b0, 3'd0, 32'h0, 32'h0);
        m0_bus.d_ready = 1'b1;
        m1_bus.d_ready = 1'b1;
        s_bus.a_ready  = 1'b1;
        s_bus.d_valid  = 1'b0;
        s_bus.d_opcode = 3'd0;
        s_bus.d_data   = 32'h0;
        s_bus.d_denied = 1'b0;
        mem[32'h10] = 32'hDEADBEEF;

        do_reset();

        // m0-only Get; a stray slave beat in IDLE must not be forwarded or accepted
        @(negedge clk_24);
        s_bus.d_valid = 1'b1; s_bus.d_opcode = 3'd1; s_bus.d_data = 32'hBAD0BAD0;
        #1;
        check("stray_m0_d_valid", m0_bus.d_valid, 0);
        check("stray_s_d_ready", s_bus.d_ready, 0);
        s_bus.d_valid = 1'b0; s_bus.d_opcode = 3'd0; s_bus.d_data = 32'h0;
        set_m(0, 1'b1, 3'd4, 32'h0000_0010, 32'h0);
        serve("m0_get", 1'b0, 32'h10, 3'd1, 32'hDEADBEEF);
        set_m(0, 1'b0, 3'd0, 32'h0, 32'h0);
        #1 check("m0_get_done_busy", busy, 0);

        // Simultaneous requests from reset: m0 first, then m1 reads m0's write
        @(negedge clk_24);
        do_reset();
        set_m(0, 1'b1, 3'd0, 32'h20, 32'h11111111);
        set_m(1, 1'b1, 3'd4, 32'h20, 32'h0);
        serve("sim_m0", 1'b0, 32'h20, 3'd0, 32'h0);
        set_m(0, 1'b0, 3'd0, 32'h0, 32'h0);
        serve("sim_m1", 1'b1, 32'h20, 3'd1, 32'h11111111);
        set_m(1, 1'b0, 3'd0, 32'h0, 32'h0);

        // Continuous contention: grants alternate 0,1,0,1
        set_m(0, 1'b1, 3'd4, 32'h20, 32'h0);
        set_m(1, 1'b1, 3'd0, 32'h40, 32'h22222222);
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) serve($sformatf("rr%0d_m0", i), 1'b0, 32'h20, 3'd1, 32'h11111111);
            else            serve($sformatf("rr%0d_m1", i), 1'b1, 32'h40, 3'd0, 32'h0);
        end

        // Reset while m1 waits for its response
        set_m(0, 1'b0, 3'd0, 32'h0, 32'h0);
        set_m(1, 1'b1, 3'd4, 32'h40, 32'h0);
        @(negedge clk_24); #1;
        check("rstmid_grant", grant, 1);
        @(negedge clk_24); #1;
        check("rstmid_dwait_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk_24);
        rst = 1'b0;
        set_m(1, 1'b0, 3'd0, 32'h0, 32'h0);
        s_bus.d_valid = 1'b1; s_bus.d_opcode = 3'd1; s_bus.d_data = 32'h22222222;
        #1;
        check("rstmid_busy", busy, 0);
        check("rstmid_m1_d_valid", m1_bus.d_valid, 0);
        s_bus.d_valid = 1'b0; s_bus.d_opcode = 3'd0; s_bus.d_data = 32'h0;
        set_m(0, 1'b1, 3'd4, 32'h20, 32'h0);
        set_m(1, 1'b1, 3'd4, 32'h40, 32'h0);
        serve("post_rst_m0", 1'b0, 32'h20, 3'd1, 32'h11111111);
        set_m(0, 1'b0, 3'd0, 32'h0, 32'h0);
        serve("post_rst_m1", 1'b1, 32'h40, 3'd1, 32'h22222222);
        set_m(1, 1'b0, 3'd0, 32'h0, 32'h0);

`ifdef TLUL_ARB_TIMEOUT_EN
        // Silent slave: 8 D_WAIT cycles, then a denied AccessAckData of zero
        set_m(1, 1'b1, 3'd4, 32'h40, 32'h0);
        @(negedge clk_24); #1;
        check("to_grant", grant, 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_24); #1;
            check($sformatf("to_wait%0d_d_valid", i), m1_bus.d_valid, 0);
        end
        set_m(1, 1'b0, 3'd0, 32'h0, 32'h0);
        @(negedge clk_24); #1;
        check("to_d_valid", m1_bus.d_valid, 1);
        check("to_d_opcode", m1_bus.d_opcode, 1);
        check("to_d_denied", m1_bus.d_denied, 1);
        check("to_d_data", m1_bus.d_data, 0);
        check("to_s_d_ready", s_bus.d_ready, 1);
        @(negedge clk_24); #1;
        check("to_idle_busy", busy, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
